vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks; H_TOTAL = sum = 800.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines; V_TOTAL = sum = 525.
REQ-009 SHALL have parameter SYNC_NEG, default 1, 1 = syncs active-low.
REQ-010 SHALL have port clk, input, 1, 25.175 MHz pixel clock from the shared PLL.
REQ-011 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-012 SHALL have port pll_locked, input, 1, PLL lock flag, asynchronous to logic.
REQ-013 SHALL have ports hsync and vsync, output, 1 each, sync pulses at SYNC_NEG polarity.
REQ-014 SHALL have port display_en, output, 1, high in the visible region.
REQ-015 SHALL have ports pos_x and pos_y, output, 10 each, current pixel column and line.
REQ-016 SHALL have ports line_start and frame_start, output, 1 each, single-cycle pulses.
REQ-017 SHALL have port frame_count, output, 8, completed-frame counter for LED and status use.

Function
REQ-018 pll_locked SHALL pass through a 2-flop synchronizer before any use.
REQ-019 FSM states SHALL be IDLE, SETTLE and RUN.
- IDLE -> SETTLE on synced lock = 1.
- SETTLE -> RUN after 16 consecutive synced-lock cycles.
- Any state -> IDLE on synced lock = 0.
REQ-020 h_cnt SHALL count 0..H_TOTAL-1 in RUN and wrap to 0; v_cnt SHALL increment at h_cnt = H_TOTAL-1 and wrap to 0 after V_TOTAL-1.
REQ-021 Outside RUN, h_cnt and v_cnt SHALL be held at 0, and all outputs SHALL hold reset values except frame_count, which holds its value.
REQ-022 All outputs SHALL be registered, with exactly 1 clock latency from the counters; pos_x/pos_y SHALL equal the h_cnt/v_cnt values that produced the other outputs in the same cycle.
REQ-023 hsync SHALL be active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751 by default).
REQ-024 vsync SHALL be active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491 by default), for whole lines.
REQ-025 display_en SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-026 line_start SHALL be 1 iff h = 0 in RUN; frame_start SHALL be 1 iff h = 0 and v = 0 in RUN.
REQ-027 frame_count SHALL increment by 1 at h = H_TOTAL-1, v = V_TOTAL-1, and wrap 255 -> 0.
REQ-028 A lock drop mid-frame SHALL abort the frame with no frame_count increment; the next RUN entry SHALL restart at (0,0).

Reset
REQ-029 While rst = 1, without any clock edge:
- state = IDLE; synchronizer and counters = 0.
- hsync and vsync inactive (1 when SYNC_NEG = 1).
- display_en, pos_x, pos_y, line_start, frame_start, frame_count = 0.
REQ-030 Release of rst SHALL resume operation from IDLE on the next clock.

Structure
REQ-031 A shared package vga_timing_pkg SHALL hold the default timing constants and the FSM state encoding, for reuse by the VGA top and the LED test.
REQ-032 The horizontal and vertical counters SHALL each be an instance of one sub-module, vga_axis_counter, with parameter TOTAL, inputs inc/clear, and outputs count/wrap.

Verification
REQ-033 Lock held at 1 from reset release -> RUN entered on cycle 18, first frame_start and line_start high on cycle 19, pos = (0,0).
REQ-034 One full default frame:
- hsync period 800 and width 96.
- 525 line_starts between frame_starts.
- vsync width 1600 clocks.
- frame period 420000 clocks.
REQ-035 One full frame -> display_en high for exactly 307200 cycles; never high when pos_x >= 640 or pos_y >= 480.
REQ-036 Lock dropped at pos (300,200) -> outputs idle within 3 clocks and frame_count unchanged; relock -> RUN after 18 clocks, restarting at (0,0).
REQ-037 Reduced parameters (H 4/1/1/1, V 2/1/1/1) run for 256 frames -> frame_count steps 255 -> 0.
REQ-038 rst asserted mid-line, between clock edges -> all outputs at reset values immediately; deassert -> sequence of REQ-033 repeats.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the controller state encoding,
// shared by the VGA timing generator and the LED test.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned CNT_W         = 10;
    localparam int unsigned FC_W          = 8;
    localparam int unsigned SETTLE_CYCLES = 16;
    localparam int unsigned SETTLE_W      = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } vga_state_t;

    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter used for both the horizontal and vertical axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = 800
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    assign wrap = inc && (count == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/timing generator: waits for a settled PLL lock, then scans the
// raster and emits registered sync, blanking, position and frame markers.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SYNC_NEG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             display_en,
    output logic [CNT_W-1:0] pos_x,
    output logic [CNT_W-1:0] pos_y,
    output logic             line_start,
    output logic             frame_start,
    output logic [FC_W-1:0]  frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_LO = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_HI = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_LO = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_HI = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_OFF = (SYNC_NEG != 0);
    localparam logic SYNC_ON  = (SYNC_NEG == 0);

    logic                lock_meta;
    logic                lock_s;
    vga_state_t          state;
    vga_state_t          state_nxt;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_cnt_nxt;
    logic                run_p0;
    logic [CNT_W-1:0]    h_cnt_p0;
    logic [CNT_W-1:0]    v_cnt_p0;
    logic                h_wrap_p0;
    logic                v_wrap_p0;

    logic                hsync_p1;
    logic                vsync_p1;
    logic                display_en_p1;
    logic [CNT_W-1:0]    pos_x_p1;
    logic [CNT_W-1:0]    pos_y_p1;
    logic                line_start_p1;
    logic                frame_start_p1;
    logic [FC_W-1:0]     frame_count_p1;

    // pll_locked comes from another clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    // settle_cnt counts synced-lock samples seen so far, including the IDLE one
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        if (!lock_s) begin
            state_nxt      = IDLE;
            settle_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_W'(1);
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        state_nxt = RUN;
                    end else begin
                        settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
                    end
                end
                RUN:     state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Gating with lock_s makes a lost lock blank the outputs on the same edge.
    always_comb begin
        run_p0 = (state == RUN) && lock_s;
    end

    // Stage p0: raster position counters
    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (run_p0),
        .clear (!run_p0),
        .count (h_cnt_p0),
        .wrap  (h_wrap_p0)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (h_wrap_p0),
        .clear (!run_p0),
        .count (v_cnt_p0),
        .wrap  (v_wrap_p0)
    );

    // Stage p1: registered outputs decoded from the p0 position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_p1       <= SYNC_OFF;
            vsync_p1       <= SYNC_OFF;
            display_en_p1  <= 1'b0;
            pos_x_p1       <= '0;
            pos_y_p1       <= '0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
            frame_count_p1 <= '0;
        end else if (run_p0) begin
            hsync_p1       <= in_window(h_cnt_p0, HS_LO, HS_HI) ? SYNC_ON : SYNC_OFF;
            vsync_p1       <= in_window(v_cnt_p0, VS_LO, VS_HI) ? SYNC_ON : SYNC_OFF;
            display_en_p1  <= (h_cnt_p0 < H_VIS) && (v_cnt_p0 < V_VIS);
            pos_x_p1       <= h_cnt_p0;
            pos_y_p1       <= v_cnt_p0;
            line_start_p1  <= (h_cnt_p0 == '0);
            frame_start_p1 <= (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
            if (v_wrap_p0) begin
                frame_count_p1 <= frame_count_p1 + FC_W'(1);
            end
        end else begin
            hsync_p1       <= SYNC_OFF;
            vsync_p1       <= SYNC_OFF;
            display_en_p1  <= 1'b0;
            pos_x_p1       <= '0;
            pos_y_p1       <= '0;
            line_start_p1  <= 1'b0;
            frame_start_p1 <= 1'b0;
        end
    end

    assign hsync       = hsync_p1;
    assign vsync       = vsync_p1;
    assign display_en  = display_en_p1;
    assign pos_x       = pos_x_p1;
    assign pos_y       = pos_y_p1;
    assign line_start  = line_start_p1;
    assign frame_start = frame_start_p1;
    assign frame_count = frame_count_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, small and tiny timing instances.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } vga_out_t;

    typedef struct {
        int       cyc;
        int       lock;
        vga_out_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: default 640x480 timing, active-low syncs
    logic rst_a = 1'b0, lock_a = 1'b0;
    logic hs_a, vs_a, de_a, ls_a, fs_a;
    logic [9:0] px_a, py_a;
    logic [7:0] fc_a;
    vga_out_t out_a;
    assign out_a = {hs_a, vs_a, de_a, px_a, py_a, ls_a, fs_a, fc_a};

    vga_timing_gen u_dut_a (
        .clk(clk), .rst(rst_a), .pll_locked(lock_a),
        .hsync(hs_a), .vsync(vs_a), .display_en(de_a),
        .pos_x(px_a), .pos_y(py_a),
        .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
    );

    // Instance B: 35x21 raster, active-high syncs, checked against a model
    localparam int BH_TOT = 35;
    localparam int BV_TOT = 21;
    localparam int B_FRAME = BH_TOT * BV_TOT;
    logic rst_b = 1'b0, lock_b = 1'b0, chk_b = 1'b0;
    logic hs_b, vs_b, de_b, ls_b, fs_b;
    logic [9:0] px_b, py_b;
    logic [7:0] fc_b;
    vga_out_t out_b, exp_b;
    assign out_b = {hs_b, vs_b, de_b, px_b, py_b, ls_b, fs_b, fc_b};

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4), .SYNC_NEG(0)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .pll_locked(lock_b),
        .hsync(hs_b), .vsync(vs_b), .display_en(de_b),
        .pos_x(px_b), .pos_y(py_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    // Instance C: 7x5 raster for frame_count wrap
    logic rst_c = 1'b0, lock_c = 1'b0;
    logic hs_c, vs_c, de_c, ls_c, fs_c;
    logic [9:0] px_c, py_c;
    logic [7:0] fc_c;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut_c (
        .clk(clk), .rst(rst_c), .pll_locked(lock_c),
        .hsync(hs_c), .vsync(vs_c), .display_en(de_c),
        .pos_x(px_c), .pos_y(py_c),
        .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
    );

    function automatic vga_out_t o(int hs, int vs, int de, int x, int y, int ls, int fs, int fc);
        vga_out_t r;
        r.hs = (hs != 0);
        r.vs = (vs != 0);
        r.de = (de != 0);
        r.x  = 10'(x);
        r.y  = 10'(y);
        r.ls = (ls != 0);
        r.fs = (fs != 0);
        r.fc = 8'(fc);
        return r;
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input vga_out_t got, input vga_out_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d, expected hs=%0b vs=%0b de=%0b x=%0d y=%0d ls=%0b fs=%0b fc=%0d",
                     name, $time, got.hs, got.vs, got.de, got.x, got.y, got.ls, got.fs, got.fc,
                     exp.hs, exp.vs, exp.de, exp.x, exp.y, exp.ls, exp.fs, exp.fc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model for B: lock seen by the controller is the input two
    // edges late; the raster runs once the seen lock has been high for more
    // than 16 consecutive edges, and the pixel is a linear index in the frame.
    int m_s1, m_s2, m_seen, m_streak, m_idx, m_fc, m_h, m_v;
    always @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            m_s1 = 0; m_s2 = 0; m_streak = 0; m_idx = 0; m_fc = 0;
            exp_b = o(0, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            m_seen = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(lock_b);
            m_streak = (m_seen != 0) ? ((m_streak < 100) ? m_streak + 1 : 100) : 0;
            if (m_streak >= 17) begin
                m_h = m_idx % BH_TOT;
                m_v = m_idx / BH_TOT;
                if (m_idx == B_FRAME - 1) m_fc = (m_fc + 1) % 256;
                exp_b = o(int'(m_h >= 24 && m_h <= 29), int'(m_v >= 14 && m_v <= 16),
                          int'(m_h < 20 && m_v < 12), m_h, m_v,
                          int'(m_h == 0), int'(m_idx == 0), m_fc);
                m_idx = (m_idx + 1) % B_FRAME;
            end else begin
                m_idx = 0;
                exp_b = o(0, 0, 0, 0, 0, 0, 0, m_fc);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (chk_b) check_out("b_model", out_b, exp_b);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[13];
    vga_out_t idle_a;
    int cyc, guard, w, p, n, fc0;
    int de_n, ls_n, vs_n, hs_n, fs_n, bad_n;

    initial begin
        idle_a = o(1, 1, 0, 0, 0, 0, 0, 0);
        vecs[0]  = '{1,    1, idle_a};
        vecs[1]  = '{18,   1, idle_a};
        vecs[2]  = '{19,   1, o(1, 1, 1, 0,   0, 1, 1, 0)};
        vecs[3]  = '{20,   1, o(1, 1, 1, 1,   0, 0, 0, 0)};
        vecs[4]  = '{658,  1, o(1, 1, 1, 639, 0, 0, 0, 0)};
        vecs[5]  = '{659,  1, o(1, 1, 0, 640, 0, 0, 0, 0)};
        vecs[6]  = '{674,  1, o(1, 1, 0, 655, 0, 0, 0, 0)};
        vecs[7]  = '{675,  1, o(0, 1, 0, 656, 0, 0, 0, 0)};
        vecs[8]  = '{770,  1, o(0, 1, 0, 751, 0, 0, 0, 0)};
        vecs[9]  = '{771,  1, o(1, 1, 0, 752, 0, 0, 0, 0)};
        vecs[10] = '{818,  1, o(1, 1, 0, 799, 0, 0, 0, 0)};
        vecs[11] = '{819,  1, o(1, 1, 1, 0,   1, 1, 0, 0)};
        vecs[12] = '{2319, 1, o(0, 1, 0, 700, 2, 0, 0, 0)};

        // Asynchronous reset before any clock edge
        #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;
        check_out("a_reset_no_clk", out_a, idle_a);
        check_out("b_reset_no_clk", out_b, o(0, 0, 0, 0, 0, 0, 0, 0));

        // A: lock held from reset release, table-driven
        lock_a = 1'b1;
        @(negedge clk) rst_a = 1'b0;
        cyc = 0;
        foreach (vecs[i]) begin
            lock_a = vecs[i].lock[0];
            while (cyc < vecs[i].cyc) begin
                @(posedge clk);
                cyc++;
            end
            #1;
            check_out($sformatf("a_vec_c%0d", vecs[i].cyc), out_a, vecs[i].exp);
        end

        // A: hsync width and period
        guard = 0;
        while (hs_a !== 1'b1 && guard < 1000) begin tick(); guard++; end
        while (hs_a !== 1'b0 && guard < 2000) begin tick(); guard++; end
        w = 0;
        while (hs_a === 1'b0 && w < 2000) begin tick(); w++; end
        p = w;
        while (hs_a === 1'b1 && p < 2000) begin tick(); p++; end
        check_int("a_hsync_width", w, 96);
        check_int("a_hsync_period", p, 800);

        // A: lock drop at x=300 blanks within 3 clocks, relock restarts
        guard = 0;
        while (px_a != 10'd300 && guard < 1000) begin tick(); guard++; end
        check_int("a_reach_x300", int'(px_a), 300);
        fc0 = int'(fc_a);
        lock_a = 1'b0;
        repeat (3) tick();
        check_out("a_lockdrop_idle", out_a, o(1, 1, 0, 0, 0, 0, 0, fc0));
        repeat (5) tick();
        lock_a = 1'b1;
        n = 0;
        while (fs_a !== 1'b1 && n < 100) begin tick(); n++; end
        check_int("a_relock_latency", n, 19);
        check_out("a_relock_origin", out_a, o(1, 1, 1, 0, 0, 1, 1, fc0));

        // A: asynchronous reset mid-line
        repeat (500) tick();
        check_int("a_pre_reset_x", int'(px_a), 500);
        #3 rst_a = 1'b1;
        #1 check_out("a_midline_reset", out_a, idle_a);
        @(negedge clk) rst_a = 1'b0;
        repeat (18) tick();
        check_out("a_rst_c18", out_a, idle_a);
        tick();
        check_out("a_rst_c19", out_a, o(1, 1, 1, 0, 0, 1, 1, 0));

        // B: one full frame with lock held, then random lock drops/resets
        chk_b = 1'b1;
        lock_b = 1'b1;
        @(negedge clk) rst_b = 1'b0;
        guard = 0;
        while (fs_b !== 1'b1 && guard < 100) begin tick(); guard++; end
        check_int("b_first_fs", int'(fs_b), 1);
        de_n = 0; ls_n = 0; vs_n = 0; hs_n = 0; fs_n = 0; bad_n = 0;
        for (int i = 0; i < B_FRAME; i++) begin
            if (i != 0) tick();
            de_n += int'(de_b);
            ls_n += int'(ls_b);
            vs_n += int'(vs_b);
            hs_n += int'(hs_b);
            fs_n += int'(fs_b);
            if (de_b && (px_b >= 10'd20 || py_b >= 10'd12)) bad_n++;
        end
        tick();
        check_int("b_frame_period", int'(fs_b), 1);
        check_int("b_de_count", de_n, 240);
        check_int("b_line_starts", ls_n, 21);
        check_int("b_vsync_clocks", vs_n, 105);
        check_int("b_hsync_clocks", hs_n, 126);
        check_int("b_frame_starts", fs_n, 1);
        check_int("b_de_outside", bad_n, 0);

        for (int i = 0; i < 12000; i++) begin
            tick();
            if ($urandom_range(0, 599) == 0) begin
                lock_b = 1'b0;
                repeat ($urandom_range(1, 40)) tick();
                lock_b = 1'b1;
            end else if ($urandom_range(0, 3999) == 0) begin
                #3 rst_b = 1'b1;
                @(negedge clk) rst_b = 1'b0;
            end
        end
        chk_b = 1'b0;

        // C: frame_count across 257 frame starts, covering 255 -> 0
        lock_c = 1'b1;
        @(negedge clk) rst_c = 1'b0;
        guard = 0;
        while (fs_c !== 1'b1 && guard < 100) begin tick(); guard++; end
        for (int f = 0; f <= 256; f++) begin
            check_int($sformatf("c_fc_frame%0d", f), int'(fc_c), f % 256);
            if (f < 256) begin
                n = 0;
                tick();
                n++;
                while (fs_c !== 1'b1 && n < 40) begin tick(); n++; end
                if (f < 2) check_int("c_frame_period", n, 35);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
